// File: rtl/uartrx.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling, LSB-first byte assembly.
// Latency: rx_valid rises about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after the start edge.
// Backpressure: none on the line; an unacked byte is overwritten and overrun is flagged.
module uartrx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic [WIDTH-1:0] rx_byte,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             rx_busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [CW-1:0]    bit_cnt;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;

    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;

            // Ack clears first; any set event below in the same cycle overrides it.
            if (rx_ack) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_cnt == HALF) begin
                        bit_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[WIDTH-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            // Leave mid stop bit so the next start edge is caught promptly.
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_ack) begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uartrx.sv
// Directed bench for uartrx at 8 clocks per bit; expected bytes flow through a scoreboard queue.
module tb_uartrx;

    localparam int CPB = 8;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         checks;
    int         errors;
    int         rise_at;
    logic [7:0] exp_q[$];

    uartrx #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one full frame, optionally pulsing rx_ack on cycle ack_at.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at, input bit expect_ok);
        logic [9:0] fr;
        logic       prev;
        fr      = {stop, b, 1'b0};
        rise_at = -1;
        if (expect_ok) exp_q.push_back(b);
        for (int c = 0; c < 10 * CPB; c++) begin
            rx     = fr[c / CPB];
            rx_ack = (c == ack_at);
            prev   = rx_valid;
            @(negedge clk);
            if (rx_valid && !prev && rise_at < 0) rise_at = c + 1;
        end
        rx_ack = 1'b0;
    endtask

    task automatic check_byte(input string tag);
        logic [7:0] e;
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_byte"}, rx_byte, e);
            chk({tag, "_valid"}, rx_valid, 1);
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [9:0] fr;
        checks = 0;
        errors = 0;
        rx     = 1'b1;
        rx_ack = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte", rx_byte, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        idle(5);

        // Single frame, latency and ack
        send_frame(8'h5A, 1'b1, -1, 1'b1);
        chk("single_latency", rise_at, 2 + CPB / 2 + 9 * CPB + 1);
        check_byte("single");
        pulse_ack();
        chk("single_ack_valid", rx_valid, 0);
        chk("single_ack_hold", rx_byte, 8'h5A);
        chk("single_idle_busy", rx_busy, 0);

        // Glitch rejection
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_hi", rx_busy, 1);
        idle(10);
        chk("glitch_busy_lo", rx_busy, 0);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_ferr", frame_err, 0);
        send_frame(8'hC3, 1'b1, -1, 1'b1);
        check_byte("after_glitch");
        pulse_ack();

        // Framing error and break
        send_frame(8'hFF, 1'b0, -1, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr_set", frame_err, 1);
        chk("ferr_valid", rx_valid, 0);
        chk("ferr_byte_kept", rx_byte, 8'hC3);
        chk("ferr_break_busy", rx_busy, 1);
        idle(4);
        chk("ferr_break_exit", rx_busy, 0);
        send_frame(8'h11, 1'b1, -1, 1'b1);
        check_byte("after_ferr");
        chk("ferr_sticky", frame_err, 1);
        pulse_ack();
        chk("ferr_cleared", frame_err, 0);
        chk("ferr_ack_valid", rx_valid, 0);
        idle(3);

        // Overrun on back-to-back frames
        send_frame(8'h01, 1'b1, -1, 1'b1);
        check_byte("ovr_first");
        chk("ovr_not_yet", overrun, 0);
        send_frame(8'h02, 1'b1, -1, 1'b1);
        check_byte("ovr_second");
        chk("ovr_set", overrun, 1);
        pulse_ack();
        chk("ovr_cleared", overrun, 0);
        chk("ovr_ack_valid", rx_valid, 0);
        idle(3);

        // Ack on the stop-sample cycle of a new frame
        send_frame(8'h3C, 1'b1, -1, 1'b1);
        check_byte("coll_pending");
        send_frame(8'hA5, 1'b1, 2 + CPB / 2 + 9 * CPB, 1'b1);
        check_byte("coll_new");
        chk("coll_no_ovr", overrun, 0);
        idle(3);

        // Reset mid-frame, A5 still pending
        fr = {1'b1, 8'h77, 1'b0};
        for (int c = 0; c < 5 * CPB + CPB / 2; c++) begin
            rx = fr[c / CPB];
            @(negedge clk);
        end
        chk("rstmid_busy_before", rx_busy, 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstmid_byte", rx_byte, 0);
        chk("rstmid_valid", rx_valid, 0);
        chk("rstmid_busy", rx_busy, 0);
        rst_n = 1'b1;
        idle(60);
        chk("rstmid_no_frame", rx_valid, 0);
        chk("rstmid_ferr_idle", frame_err, 0);
        send_frame(8'h9E, 1'b1, -1, 1'b1);
        check_byte("rstmid_9e");
        chk("rstmid_ferr", frame_err, 0);
        chk("rstmid_ovr", overrun, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
